serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_fa_cell.sv | 19 +
 rtl/serial_adder.sv | 157 +++++++++++++++
 tb/tb_serial_adder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// legal operand-width range, plus a helper used for the elaboration-time width check.
// Combinational/typedef-only; no latency, no flow control.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_WIDTH_MIN = 2;
    localparam int SA_WIDTH_MAX = 32;

    function automatic bit sa_width_ok(input int w);
        return (w >= SA_WIDTH_MIN) && (w <= SA_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder cell used by the serial adder datapath.
// Latency: purely combinational (0 cycles).
// Backpressure: none; outputs follow inputs.
// Ports: a, b, c -- addend bits and carry-in; sum, cout -- sum bit and carry-out.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);

    logic half;

    assign half = a ^ b;
    assign sum  = half ^ c;
    assign cout = (a & b) | (c & half);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + cin one bit per cycle through a single fa_cell.
// Latency: WIDTH+1 rising edges from accept to out_valid; one result per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE (no queueing); result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n            -- clock, asynchronous active-low reset
//   in_valid/in_ready     -- operand handshake carrying a, b, cin
//   out_valid/out_ready   -- result handshake carrying sum, cout (and ovf)
// Optional: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    if (!sa_width_ok(WIDTH)) begin : g_width_check
        $error("serial_adder: WIDTH out of supported range");
    end

    sa_state_t        state_q;
    sa_state_t        state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    // Holds the WIDTH-1 sum bits produced so far; the final bit is merged
    // directly into the result register on the last RUN cycle.
    logic [WIDTH-2:0] s_q;
    logic [WIDTH-1:0] s_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .c    (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = in_valid && in_ready;
    assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
    assign s_nxt    = {fa_sum, s_q};

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Serial datapath. The result registers are written only on the last
    // RUN cycle, so sum/cout stay frozen while the next operation shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            s_q     <= s_nxt[WIDTH-1:1];
            carry_q <= fa_cout;
            // Counter saturates at WIDTH-1 so it never wraps inside a run.
            if (!last_bit) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                sum_q  <= s_nxt;
                cout_q <= fa_cout;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the last cycle carry_q is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= carry_q ^ fa_cout;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed corner cases plus random traffic,
// checked by a queue-based scoreboard fed from an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_sent = 0;
    int   n_out  = 0;
    bit   rand_done;

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t e;
        int   u;
        int   sx;
        int   sy;
        int   ss;
        u   = int'(x) + int'(y) + int'(ci);
        e.s = W'(u % (1 << W));
        e.c = (u >= (1 << W));
        sx  = int'(x) - (x[W-1] ? (1 << W) : 0);
        sy  = int'(y) - (y[W-1] ? (1 << W) : 0);
        ss  = sx + sy + int'(ci);
        e.o = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive/sample point for the stimulus thread: well away from the rising edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int g;
        g = 0;
        while (in_ready !== 1'b1 && g < 200) begin
            step();
            g++;
        end
        chk("send_in_ready", {31'd0, in_ready}, 32'd1);
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        q.push_back(model(x, y, ci));
        n_sent++;
        step();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
    endtask

    // Count edges from the accept edge until out_valid rises.
    task automatic measure_latency(input string name);
        int n;
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(name, n, 9);
    endtask

    task automatic wait_out(input string name);
        int g;
        g = 0;
        while (out_valid !== 1'b1 && g < 40) begin
            step();
            g++;
        end
        chk(name, {31'd0, out_valid}, 32'd1);
    endtask

    // Scoreboard monitor: pops one expectation per completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: sum=%0h cout=%0b with no pending request", sum, cout);
                end else begin
                    e = q.pop_front();
                    n_out++;
                    chk("sb_sum", {24'd0, sum}, {24'd0, e.s});
                    chk("sb_cout", {31'd0, cout}, {31'd0, e.c});
`ifdef SERIAL_ADDER_OVF_EN
                    chk("sb_ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   g;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        rand_done = 1'b0;
        step();
        step();

        // Reset state.
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic add with latency measurement.
        send(8'h0F, 8'h01, 1'b0);
        chk("run_in_ready", {31'd0, in_ready}, 32'd0);
        chk("run_out_valid", {31'd0, out_valid}, 32'd0);
        measure_latency("latency_0f_01");
        step();

        // Carry corners and signed-overflow corners, back to back.
        send(8'hFF, 8'h01, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        send(8'h7F, 8'h01, 1'b0);
        send(8'h80, 8'h80, 1'b0);
        send(8'h00, 8'h00, 1'b0);
        wait_out("corner_last_done");
        step();

        // Output stall: result frozen for 5 cycles, then IDLE one edge after release.
        out_ready = 1'b0;
        send(8'hC3, 8'h5A, 1'b1);
        e = model(8'hC3, 8'h5A, 1'b1);
        wait_out("stall_done");
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_sum", {24'd0, sum}, {24'd0, e.s});
            chk("stall_cout", {31'd0, cout}, {31'd0, e.c});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_sum_hold", {24'd0, sum}, {24'd0, e.s});

        // Operands offered mid-run are ignored.
        send(8'h12, 8'h34, 1'b0);
        step();
        step();
        a        = 8'hAA;
        b        = 8'h55;
        cin      = 1'b1;
        in_valid = 1'b1;
        chk("midrun_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        in_valid = 1'b0;
        wait_out("midrun_done");
        step();

        // Reset in the middle of a run aborts it.
        send(8'h55, 8'h66, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum", {24'd0, sum}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        q.delete();
        n_sent--;
        step();
        rst_n = 1'b1;
        step();
        send(8'h01, 8'h02, 1'b0);
        measure_latency("latency_after_reset");
        step();

        // Random traffic with random output backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    step();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;

        g = 0;
        while (q.size() != 0 && g < 200) begin
            step();
            g++;
        end
        step();
        chk("drain_queue_empty", q.size(), 0);
        chk("result_count", n_out, n_sent);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
